jstk2_responder: RTL and testbench
==================================

JSTK2_RESPONDER -- requirements
Module: jstk2_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth on sck, cs_n and mosi.
REQ-002 Parameter PACKET_BYTES, default 5: bytes per JSTK2 frame.
REQ-003 clk  input  1  100 MHz system clock; the only clock.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 sck  input  1  SPI clock from the initiator, asynchronous to clk.
REQ-006 cs_n  input  1  SPI chip select from the initiator, active-low.
REQ-007 mosi  input  1  SPI data from the initiator.
REQ-008 miso  output  1  SPI data to the initiator.
REQ-009 x_pos  input  10  emulated joystick X value.
REQ-010 y_pos  input  10  emulated joystick Y value.
REQ-011 buttons  input  2  emulated buttons: bit0 joystick, bit1 trigger.
REQ-012 rx_byte  output  8  last complete received byte.
REQ-013 rx_index  output  3  position of rx_byte in the frame (0..PACKET_BYTES-1).
REQ-014 rx_valid  output  1  one-cycle pulse when rx_byte/rx_index update.
REQ-015 led_rgb  output  24  {R,G,B} from the last valid set-LED frame.
REQ-016 led_update  output  1  one-cycle pulse when led_rgb changes.
REQ-017 busy  output  1  high while a frame is active (synchronized cs_n low).
REQ-018 frame_abort  output  1  one-cycle pulse when cs_n rises mid-byte.

Function
REQ-019 sck, cs_n and mosi SHALL pass through SYNC_STAGES flops; all edges are detected in the clk domain; sck high and low phases are each at least 4 clk.
REQ-020 SPI mode 0: mosi SHALL be sampled on detected sck rise; miso SHALL change only on detected sck fall or cs_n fall; both directions MSB first.
REQ-021 On detected cs_n fall, the block SHALL snapshot the 40-bit tx frame {x_pos[7:0], 6'b0,x_pos[9:8], y_pos[7:0], 6'b0,y_pos[9:8], 6'b0,buttons} and drive bit 39 on miso on the next cycle.
REQ-022 Frame inputs changing during an active frame SHALL NOT affect the frame being sent.
REQ-023 miso SHALL update at most SYNC_STAGES+1 clk cycles after the sck fall at the pins.
REQ-024 A 3-bit bit counter and a 3-bit byte counter SHALL track position; after the 8th sck rise of a byte, rx_byte and rx_index SHALL load and rx_valid SHALL pulse in the same cycle.
REQ-025 Bytes beyond PACKET_BYTES SHALL drive miso 0 and produce no rx_valid; the byte counter SHALL saturate at PACKET_BYTES.
REQ-026 States: IDLE (cs_n high, miso 0), SHIFT (frame active), DONE (all bytes received, cs_n still low); IDLE->SHIFT on cs_n fall; SHIFT->DONE after byte PACKET_BYTES-1; SHIFT/DONE->IDLE on cs_n rise.
REQ-027 cs_n rise with bit counter nonzero SHALL discard the partial byte, pulse frame_abort, and return to IDLE; counters SHALL clear on every cs_n rise.
REQ-028 If byte 0 equals CMD_SET_LED (8'h84) and bytes 1..3 complete before cs_n rises, led_rgb SHALL load {byte1,byte2,byte3} and led_update SHALL pulse the cycle after the byte-3 rx_valid.
REQ-029 An aborted or short set-LED frame SHALL leave led_rgb unchanged.
REQ-030 A cs_n rise and an sck edge detected in the same cycle: the cs_n rise SHALL win, and the sck edge SHALL be ignored.

Reset
REQ-031 While rst is high: state IDLE; miso, rx_byte, rx_index, rx_valid, led_rgb, led_update, busy and frame_abort all 0; synchronizers preset to idle levels (sck 0, cs_n 1).
REQ-032 rst during a frame SHALL abandon it without a frame_abort pulse; after rst falls, the next cs_n fall starts a fresh frame.

Structure
REQ-033 Package jstk2_pkg SHALL hold CMD_SET_LED, PACKET_BYTES default, the frame-layout constants and the state encoding.
REQ-034 A single sub-module spi_sync_edge (synchronizer plus rise/fall detect) SHALL be instantiated for sck, cs_n and mosi.

Verification
REQ-035 x_pos=10'h2A5, y_pos=10'h0F3, buttons=2'b10, 5-byte read: miso returns A5,02,F3,00,02; rx_valid pulses 5 times with rx_index 0..4.
REQ-036 Frame 84,11,22,33,00: led_rgb becomes 24'h112233 with one led_update pulse; bytes returned on miso still match the joystick frame.
REQ-037 cs_n rises after 3 bits of byte 2: one frame_abort pulse, only 2 rx_valid pulses, busy falls; the next frame returns byte 0 first.
REQ-038 Frame 84,AA,BB then cs_n rises: led_rgb keeps its previous value and led_update does not pulse.
REQ-039 7-byte frame: bytes 5 and 6 read 00 on miso, no extra rx_valid; x_pos changed mid-frame: the next frame reflects the new value.
REQ-040 rst asserted mid-byte 1: all outputs 0 on the next clk edge, no frame_abort; a following full frame reads correctly.

Source files
------------

// File: rtl/jstk2_pkg.sv
// rtl/jstk2_pkg.sv - constants, state encoding and tx frame builder for the JSTK2 responder
package jstk2_pkg;

  localparam logic [7:0] CMD_SET_LED      = 8'h84;
  localparam int         PACKET_BYTES_DEF = 5;
  localparam int         FRAME_BITS       = 40;
  localparam int         POS_BITS         = 10;
  localparam int         BTN_BITS         = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Each 10-bit position is sent low byte first, then its two MSBs right-aligned.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic [POS_BITS-1:0] x,
    input logic [POS_BITS-1:0] y,
    input logic [BTN_BITS-1:0] b
  );
    build_frame = {x[7:0], 6'b0, x[9:8], y[7:0], 6'b0, y[9:8], 6'b0, b};
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchronizer with rise/fall detect in the clk domain
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= r_sync[STAGES-1];
    end
  end

  // Edges are combinational so the consumer can react in the same cycle the level settles.
  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/jstk2_responder.sv
// rtl/jstk2_responder.sv - SPI mode-0 JSTK2 joystick emulator: returns position frame, captures set-LED command
module jstk2_responder
  import jstk2_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int PACKET_BYTES = PACKET_BYTES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sck,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  input  logic [9:0]  x_pos,
  input  logic [9:0]  y_pos,
  input  logic [1:0]  buttons,
  output logic [7:0]  rx_byte,
  output logic [2:0]  rx_index,
  output logic        rx_valid,
  output logic [23:0] led_rgb,
  output logic        led_update,
  output logic        busy,
  output logic        frame_abort
);

  localparam logic [2:0] PKT  = 3'(PACKET_BYTES);
  localparam logic [2:0] LAST = 3'(PACKET_BYTES - 1);

  logic w_sck_level, w_sck_rise, w_sck_fall;
  logic w_cs_level, w_cs_rise, w_cs_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall;
  logic w_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst(rst), .i_d(sck),
    .o_level(w_sck_level), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .i_d(cs_n),
    .o_level(w_cs_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .i_d(mosi),
    .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );

  assign w_unused = ^{w_sck_level, w_cs_level, w_mosi_rise, w_mosi_fall};

  state_t                r_state;
  logic [FRAME_BITS-2:0] r_tx;
  logic [6:0]            r_rx_sr;
  logic [2:0]            r_bit_cnt;
  logic [2:0]            r_byte_cnt;
  logic                  r_cmd;
  logic [7:0]            r_led_r;
  logic [7:0]            r_led_g;
  logic                  r_led_go;

  logic [FRAME_BITS-1:0] w_frame;
  logic [7:0]            w_rx_next;

  assign w_frame   = build_frame(x_pos, y_pos, buttons);
  assign w_rx_next = {r_rx_sr, w_mosi};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_tx        <= '0;
      r_rx_sr     <= '0;
      r_bit_cnt   <= '0;
      r_byte_cnt  <= '0;
      r_cmd       <= 1'b0;
      r_led_r     <= '0;
      r_led_g     <= '0;
      r_led_go    <= 1'b0;
      miso        <= 1'b0;
      rx_byte     <= '0;
      rx_index    <= '0;
      rx_valid    <= 1'b0;
      led_rgb     <= '0;
      led_update  <= 1'b0;
      busy        <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      led_update  <= 1'b0;
      frame_abort <= 1'b0;
      r_led_go    <= 1'b0;

      // Byte 3 of a set-LED frame is already in rx_byte by the time this fires.
      if (r_led_go) begin
        led_rgb    <= {r_led_r, r_led_g, rx_byte};
        led_update <= 1'b1;
      end

      if (w_cs_rise) begin
        frame_abort <= (r_state != ST_IDLE) && (r_bit_cnt != 3'd0);
        r_state     <= ST_IDLE;
        busy        <= 1'b0;
        miso        <= 1'b0;
        r_bit_cnt   <= '0;
        r_byte_cnt  <= '0;
        r_cmd       <= 1'b0;
      end else if (w_cs_fall && r_state == ST_IDLE) begin
        r_state    <= ST_SHIFT;
        busy       <= 1'b1;
        r_tx       <= w_frame[FRAME_BITS-2:0];
        miso       <= w_frame[FRAME_BITS-1];
        r_bit_cnt  <= '0;
        r_byte_cnt <= '0;
        r_cmd      <= 1'b0;
      end else if (r_state != ST_IDLE) begin
        if (w_sck_rise) begin
          r_rx_sr   <= w_rx_next[6:0];
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7 && r_byte_cnt < PKT) begin
            rx_byte    <= w_rx_next;
            rx_index   <= r_byte_cnt;
            rx_valid   <= 1'b1;
            r_byte_cnt <= r_byte_cnt + 3'd1;
            case (r_byte_cnt)
              3'd0:    r_cmd    <= (w_rx_next == CMD_SET_LED);
              3'd1:    r_led_r  <= w_rx_next;
              3'd2:    r_led_g  <= w_rx_next;
              3'd3:    r_led_go <= r_cmd;
              default: ;
            endcase
            if (r_byte_cnt == LAST) r_state <= ST_DONE;
          end
        end else if (w_sck_fall) begin
          // Byte counter already points at the byte being started; past the frame, send zeros.
          miso <= (r_byte_cnt < PKT) ? r_tx[FRAME_BITS-2] : 1'b0;
          r_tx <= {r_tx[FRAME_BITS-3:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_jstk2_responder.sv
// tb/tb_jstk2_responder.sv - directed self-checking bench for jstk2_responder
`timescale 1ns/1ps
module tb_jstk2_responder;

  logic        clk, rst, sck, cs_n, mosi, miso;
  logic [9:0]  x_pos, y_pos;
  logic [1:0]  buttons;
  logic [7:0]  rx_byte;
  logic [2:0]  rx_index;
  logic        rx_valid;
  logic [23:0] led_rgb;
  logic        led_update, busy, frame_abort;

  jstk2_responder #(.SYNC_STAGES(2), .PACKET_BYTES(5)) dut (
    .clk(clk), .rst(rst), .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .x_pos(x_pos), .y_pos(y_pos), .buttons(buttons),
    .rx_byte(rx_byte), .rx_index(rx_index), .rx_valid(rx_valid),
    .led_rgb(led_rgb), .led_update(led_update), .busy(busy), .frame_abort(frame_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int cyc = 0, rv_cnt = 0, lu_cnt = 0, fa_cnt = 0, idx3_cyc = 0, lu_cyc = 0;
  logic [7:0] rv_byte [64];
  logic [2:0] rv_idx  [64];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rx_valid) begin
      rv_byte[rv_cnt % 64] = rx_byte;
      rv_idx[rv_cnt % 64]  = rx_index;
      rv_cnt = rv_cnt + 1;
      if (rx_index == 3'd3) idx3_cyc = cyc;
    end
    if (led_update) begin
      lu_cnt = lu_cnt + 1;
      lu_cyc = cyc;
    end
    if (frame_abort) fa_cnt = fa_cnt + 1;
  end

  logic       cur_bit;
  logic [7:0] tx_buf [8];
  logic [7:0] rx_buf [8];
  logic [7:0] exp_a  [7] = '{8'hA5, 8'h02, 8'hF3, 8'h00, 8'h02, 8'h00, 8'h00};
  logic [7:0] exp_b  [5] = '{8'hFF, 8'h03, 8'hF3, 8'h00, 8'h02};

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_begin();
    cs_n = 1'b0;
    wait_clks(3);
    cur_bit = miso;
  endtask

  // miso is sampled exactly SYNC_STAGES+1 clocks after each sck fall.
  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      rx[7-i] = cur_bit;
      mosi = tx[7-i];
      wait_clks(3);
      sck = 1'b1;
      wait_clks(6);
      sck = 1'b0;
      wait_clks(3);
      cur_bit = miso;
    end
  endtask

  task automatic spi_end();
    wait_clks(3);
    cs_n = 1'b1;
    mosi = 1'b0;
    wait_clks(6);
  endtask

  task automatic run_frame(input int n);
    spi_begin();
    for (int i = 0; i < n; i++) spi_xfer(tx_buf[i], 8, rx_buf[i]);
    spi_end();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_clks(4);
    checks++;
    if ({miso, rx_byte, rx_index, rx_valid, led_rgb, led_update, busy, frame_abort} !== 40'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {miso, rx_byte, rx_index, rx_valid, led_rgb, led_update, busy, frame_abort});
    end
    rst = 1'b0;
    wait_clks(4);
    checks++;
    if ({busy, miso} !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_reset: got busy/miso %b expected 00", {busy, miso});
    end
  endtask

  task automatic test_read();
    int base;
    base = rv_cnt;
    tx_buf[0] = 8'h3C; tx_buf[1] = 8'h5A; tx_buf[2] = 8'hC3; tx_buf[3] = 8'h81; tx_buf[4] = 8'h7E;
    spi_begin();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_active: got %b expected 1", busy); end
    for (int i = 0; i < 5; i++) spi_xfer(tx_buf[i], 8, rx_buf[i]);
    spi_end();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rx_buf[i] !== exp_a[i]) begin
        errors++; $display("FAIL read_miso%0d: got %h expected %h", i, rx_buf[i], exp_a[i]);
      end
    end
    checks++;
    if (rv_cnt - base !== 5) begin errors++; $display("FAIL read_rx_valid_count: got %0d expected 5", rv_cnt - base); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rv_idx[(base+i)%64], rv_byte[(base+i)%64]} !== {i[2:0], tx_buf[i]}) begin
        errors++;
        $display("FAIL read_rx%0d: got idx %0d byte %h expected idx %0d byte %h",
                 i, rv_idx[(base+i)%64], rv_byte[(base+i)%64], i, tx_buf[i]);
      end
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_led();
    int base;
    base = lu_cnt;
    tx_buf[0] = 8'h84; tx_buf[1] = 8'h11; tx_buf[2] = 8'h22; tx_buf[3] = 8'h33; tx_buf[4] = 8'h00;
    run_frame(5);
    checks++;
    if (led_rgb !== 24'h112233) begin errors++; $display("FAIL led_value: got %h expected 112233", led_rgb); end
    checks++;
    if (lu_cnt - base !== 1) begin errors++; $display("FAIL led_update_count: got %0d expected 1", lu_cnt - base); end
    checks++;
    if (lu_cyc - idx3_cyc !== 1) begin errors++; $display("FAIL led_update_latency: got %0d expected 1", lu_cyc - idx3_cyc); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rx_buf[i] !== exp_a[i]) begin
        errors++; $display("FAIL led_miso%0d: got %h expected %h", i, rx_buf[i], exp_a[i]);
      end
    end
  endtask

  task automatic test_abort();
    int rv_base, fa_base;
    logic [7:0] junk;
    rv_base = rv_cnt;
    fa_base = fa_cnt;
    spi_begin();
    spi_xfer(8'h12, 8, junk);
    spi_xfer(8'h34, 8, junk);
    spi_xfer(8'h56, 3, junk);
    spi_end();
    checks++;
    if (fa_cnt - fa_base !== 1) begin errors++; $display("FAIL abort_pulse_count: got %0d expected 1", fa_cnt - fa_base); end
    checks++;
    if (rv_cnt - rv_base !== 2) begin errors++; $display("FAIL abort_rx_valid_count: got %0d expected 2", rv_cnt - rv_base); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    tx_buf[0] = 8'h00;
    run_frame(1);
    checks++;
    if (rx_buf[0] !== 8'hA5) begin errors++; $display("FAIL abort_next_byte0: got %h expected a5", rx_buf[0]); end
    checks++;
    if (fa_cnt - fa_base !== 1) begin errors++; $display("FAIL abort_no_extra: got %0d expected 1", fa_cnt - fa_base); end
  endtask

  task automatic test_short_led();
    int lu_base, fa_base;
    lu_base = lu_cnt;
    fa_base = fa_cnt;
    tx_buf[0] = 8'h84; tx_buf[1] = 8'hAA; tx_buf[2] = 8'hBB;
    run_frame(3);
    checks++;
    if (led_rgb !== 24'h112233) begin errors++; $display("FAIL short_led_value: got %h expected 112233", led_rgb); end
    checks++;
    if (lu_cnt - lu_base !== 0) begin errors++; $display("FAIL short_led_update: got %0d expected 0", lu_cnt - lu_base); end
    checks++;
    if (fa_cnt - fa_base !== 0) begin errors++; $display("FAIL short_led_abort: got %0d expected 0", fa_cnt - fa_base); end
  endtask

  task automatic test_long();
    int base;
    base = rv_cnt;
    spi_begin();
    spi_xfer(8'h00, 8, rx_buf[0]);
    x_pos = 10'h3FF;
    for (int i = 1; i < 7; i++) spi_xfer(8'hFF, 8, rx_buf[i]);
    spi_end();
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (rx_buf[i] !== exp_a[i]) begin
        errors++; $display("FAIL long_miso%0d: got %h expected %h", i, rx_buf[i], exp_a[i]);
      end
    end
    checks++;
    if (rv_cnt - base !== 5) begin errors++; $display("FAIL long_rx_valid_count: got %0d expected 5", rv_cnt - base); end
    tx_buf[0] = 8'h00; tx_buf[1] = 8'h00;
    run_frame(2);
    checks++;
    if ({rx_buf[0], rx_buf[1]} !== 16'hFF03) begin
      errors++; $display("FAIL long_next_frame: got %h%h expected ff03", rx_buf[0], rx_buf[1]);
    end
  endtask

  task automatic test_rst_mid();
    int fa_base, rv_base;
    logic [7:0] junk;
    fa_base = fa_cnt;
    spi_begin();
    spi_xfer(8'h5A, 8, junk);
    spi_xfer(8'hFF, 3, junk);
    checks++;
    if (rx_byte !== 8'h5A) begin errors++; $display("FAIL rst_mid_pre: got %h expected 5a", rx_byte); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({miso, rx_byte, rx_index, rx_valid, led_rgb, led_update, busy, frame_abort} !== 40'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got %h expected 0",
               {miso, rx_byte, rx_index, rx_valid, led_rgb, led_update, busy, frame_abort});
    end
    cs_n = 1'b1;
    mosi = 1'b0;
    wait_clks(4);
    rst = 1'b0;
    wait_clks(4);
    checks++;
    if (fa_cnt - fa_base !== 0) begin errors++; $display("FAIL rst_mid_abort: got %0d expected 0", fa_cnt - fa_base); end
    rv_base = rv_cnt;
    for (int i = 0; i < 5; i++) tx_buf[i] = 8'h00;
    run_frame(5);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rx_buf[i] !== exp_b[i]) begin
        errors++; $display("FAIL rst_mid_miso%0d: got %h expected %h", i, rx_buf[i], exp_b[i]);
      end
    end
    checks++;
    if (rv_idx[rv_base % 64] !== 3'd0 || rv_cnt - rv_base !== 5) begin
      errors++;
      $display("FAIL rst_mid_rx: got first idx %0d count %0d expected 0 and 5", rv_idx[rv_base % 64], rv_cnt - rv_base);
    end
  endtask

  initial begin
    rst = 1'b1; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    x_pos = 10'h2A5; y_pos = 10'h0F3; buttons = 2'b10;
    cur_bit = 1'b0;
    test_reset();
    test_read();
    test_led();
    test_abort();
    test_short_led();
    test_long();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
